// File: rtl/apb_upio_gen_if.sv
// APB slave bus bundle for the user I/O block.
interface apb_upio_gen_if #(
   parameter int ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [31:0]           PWDATA;
   logic                  PWRITE;
   logic                  PSEL;
   logic                  PENABLE;
   logic [31:0]           PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_upio_gen.sv
// APB user I/O block: direction/output registers, synchronized pin inputs
// and per-pin edge/level interrupts with W1C status.

// One pin's input path: synchronizer, history flop and sticky status bit.
module apb_upio_gen_lane #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   input  logic en,
   input  logic typ,
   input  logic pol,
   input  logic clr,
   output logic in_bit,
   output logic stat
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   evt;

   assign in_bit = sync[SYNC_STAGES-1];

   // shift the raw pin through the synchronizer; prev tracks the last IN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin};
         prev <= in_bit;
      end
   end

   // event detect: level mode looks at IN only, edge mode compares with prev
   always_comb begin
      evt = 1'b0;
      if (typ) evt = pol ? ~in_bit : in_bit;
      else     evt = pol ? (~in_bit & prev) : (in_bit & ~prev);
   end

   // sticky status; a new event beats a same-cycle W1C clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stat <= 1'b0;
      else     stat <= (en & evt) | (stat & ~clr);
   end
endmodule

module apb_upio_gen #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int UPIO_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   apb_upio_gen_if.slave         apb,
   input  logic [UPIO_WIDTH-1:0] upio_in_i,
   output logic [UPIO_WIDTH-1:0] upio_out_o,
   output logic [UPIO_WIDTH-1:0] upio_dir_o,
   output logic                  int_o
);
   localparam int IW = APB_ADDR_WIDTH - 2;
   localparam logic [IW-1:0] A_DIR  = IW'(0);
   localparam logic [IW-1:0] A_OUT  = IW'(1);
   localparam logic [IW-1:0] A_SET  = IW'(2);
   localparam logic [IW-1:0] A_CLR  = IW'(3);
   localparam logic [IW-1:0] A_IN   = IW'(4);
   localparam logic [IW-1:0] A_EN   = IW'(5);
   localparam logic [IW-1:0] A_TYPE = IW'(6);
   localparam logic [IW-1:0] A_POL  = IW'(7);
   localparam logic [IW-1:0] A_STAT = IW'(8);

   logic [IW-1:0]         idx;
   logic                  access, mapped, err, wr;
   logic [UPIO_WIDTH-1:0] wdata, clr_mask;
   logic [UPIO_WIDTH-1:0] dir_q, out_q, en_q, type_q, pol_q;
   logic [UPIO_WIDTH-1:0] in_w, stat_w;
   logic [31:0]           rdata;

   assign idx    = apb.PADDR[APB_ADDR_WIDTH-1:2];
   assign wdata  = apb.PWDATA[UPIO_WIDTH-1:0];
   assign access = apb.PSEL & apb.PENABLE;
   assign mapped = (idx <= A_STAT);
   // unmapped addresses and writes to the read-only IN register are rejected
   assign err    = ~mapped | (apb.PWRITE & (idx == A_IN));
   assign wr     = access & apb.PWRITE & ~err;

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = access & err & ~rst_i;

   // byte-lane bits and unused upper write data are intentionally ignored
   logic unused_addr;
   assign unused_addr = ^apb.PADDR[1:0];
   generate
      if (UPIO_WIDTH < 32) begin : g_wpad
         logic unused_wdata;
         assign unused_wdata = ^apb.PWDATA[31:UPIO_WIDTH];
      end
   endgenerate

   // software-visible control registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dir_q  <= '0;
         out_q  <= '0;
         en_q   <= '0;
         type_q <= '0;
         pol_q  <= '0;
      end else if (wr) begin
         case (idx)
            A_DIR:   dir_q  <= wdata;
            A_OUT:   out_q  <= wdata;
            A_SET:   out_q  <= out_q | wdata;
            A_CLR:   out_q  <= out_q & ~wdata;
            A_EN:    en_q   <= wdata;
            A_TYPE:  type_q <= wdata;
            A_POL:   pol_q  <= wdata;
            default: ;
         endcase
      end
   end

   assign clr_mask = (wr && idx == A_STAT) ? wdata : '0;

   genvar i;
   generate
      for (i = 0; i < UPIO_WIDTH; i++) begin : g_lane
         apb_upio_gen_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk    (clk_i),
            .rst    (rst_i),
            .pin    (upio_in_i[i]),
            .en     (en_q[i]),
            .typ    (type_q[i]),
            .pol    (pol_q[i]),
            .clr    (clr_mask[i]),
            .in_bit (in_w[i]),
            .stat   (stat_w[i])
         );
      end
   endgenerate

   // read mux; rejected accesses and write-only registers return zero
   always_comb begin
      rdata = '0;
      if (apb.PSEL && !err && !rst_i) begin
         case (idx)
            A_DIR:   rdata[UPIO_WIDTH-1:0] = dir_q;
            A_OUT:   rdata[UPIO_WIDTH-1:0] = out_q;
            A_IN:    rdata[UPIO_WIDTH-1:0] = in_w;
            A_EN:    rdata[UPIO_WIDTH-1:0] = en_q;
            A_TYPE:  rdata[UPIO_WIDTH-1:0] = type_q;
            A_POL:   rdata[UPIO_WIDTH-1:0] = pol_q;
            A_STAT:  rdata[UPIO_WIDTH-1:0] = stat_w;
            default: rdata = '0;
         endcase
      end
   end

   assign apb.PRDATA = rdata;
   assign upio_out_o = out_q;
   assign upio_dir_o = dir_q;
   assign int_o      = |(stat_w & en_q);
endmodule

// File: tb/tb_apb_upio_gen.sv
// Randomized bench for apb_upio_gen against a queue-based reference model.
module tb_apb_upio_gen;
   localparam int AW = 12;
   localparam int W  = 8;
   localparam int S  = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] pin = '0;
   logic [W-1:0] uout, udir;
   logic         irq;
   int           total = 0;
   int           bad   = 0;

   apb_upio_gen_if #(.ADDR_WIDTH(AW)) apb ();

   apb_upio_gen #(.APB_ADDR_WIDTH(AW), .UPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .apb        (apb.slave),
      .upio_in_i  (pin),
      .upio_out_o (uout),
      .upio_dir_o (udir),
      .int_o      (irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // hist[0] is the pin value sampled at the most recent edge; IN is the
   // sample taken S-1 edges before that, prev one edge older still.
   logic [W-1:0] m_dir = '0, m_out = '0, m_en = '0, m_typ = '0, m_pol = '0, m_stat = '0;
   logic [W-1:0] hist[$];

   function automatic logic [W-1:0] m_in();
      return hist[S-1];
   endfunction

   function automatic logic m_err(input logic w, input logic [AW-1:0] a);
      int ix = int'(a >> 2);
      return (ix > 8) || (w && ix == 4);
   endfunction

   function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
      int ix = int'(a >> 2);
      logic [31:0] r = '0;
      case (ix)
         0: r[W-1:0] = m_dir;
         1: r[W-1:0] = m_out;
         4: r[W-1:0] = m_in();
         5: r[W-1:0] = m_en;
         6: r[W-1:0] = m_typ;
         7: r[W-1:0] = m_pol;
         8: r[W-1:0] = m_stat;
         default: r = '0;
      endcase
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      logic [W-1:0] cur, old, setm, w1c, wd;
      int ix;
      if (rst) begin
         m_dir = '0; m_out = '0; m_en = '0; m_typ = '0; m_pol = '0; m_stat = '0;
         hist = {};
         for (int k = 0; k <= S; k++) hist.push_back('0);
      end else begin
         cur  = hist[S-1];
         old  = hist[S];
         setm = '0;
         for (int b = 0; b < W; b++) begin
            logic hit;
            if (m_typ[b]) hit = m_pol[b] ? (cur[b] == 1'b0) : (cur[b] == 1'b1);
            else          hit = m_pol[b] ? (old[b] && !cur[b]) : (!old[b] && cur[b]);
            if (m_en[b] && hit) setm[b] = 1'b1;
         end
         w1c = '0;
         if (apb.PSEL && apb.PENABLE && apb.PWRITE && !m_err(1'b1, apb.PADDR)) begin
            ix = int'(apb.PADDR >> 2);
            wd = apb.PWDATA[W-1:0];
            case (ix)
               0: m_dir = wd;
               1: m_out = wd;
               2: m_out = m_out | wd;
               3: m_out = m_out & ~wd;
               5: m_en  = wd;
               6: m_typ = wd;
               7: m_pol = wd;
               8: w1c   = wd;
               default: ;
            endcase
         end
         m_stat = (m_stat & ~w1c) | setm;
         hist.push_front(pin);
         void'(hist.pop_back());
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_out();
      chk("upio_out", 32'(uout), 32'(m_out));
      chk("upio_dir", 32'(udir), 32'(m_dir));
      chk("int_o", 32'(irq), 32'(|(m_stat & m_en)));
   endtask

   task automatic apb_acc(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = d;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      #1;
      rd = apb.PRDATA;
      chk("pslverr", 32'(apb.PSLVERR), 32'(m_err(w, a)));
      chk("pready", 32'(apb.PREADY), 32'd1);
      if (!w) chk("prdata", apb.PRDATA, m_rd(a));
      @(posedge clk);
      #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      logic [31:0] rd;
      apb_acc(1'b1, a, d, rd);
   endtask

   task automatic rd_reg(input logic [AW-1:0] a, output logic [31:0] rd);
      apb_acc(1'b0, a, 32'h0, rd);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r;
      for (int k = 0; k <= S; k++) hist.push_back('0);
      apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;

      // reset state
      #23;
      chk("rst_out", 32'(uout), 32'h0);
      chk("rst_dir", 32'(udir), 32'h0);
      chk("rst_int", 32'(irq), 32'h0);
      chk("rst_prdata", apb.PRDATA, 32'h0);
      chk("rst_pready", 32'(apb.PREADY), 32'h1);
      chk("rst_pslverr", 32'(apb.PSLVERR), 32'h0);
      @(negedge clk); rst = 1'b0;

      // output register path with set/clear aliases
      wr(12'h000, 32'hF0);
      wr(12'h004, 32'h0F);
      wr(12'h008, 32'h30);
      wr(12'h00C, 32'h01);
      chk("dir_f0", 32'(udir), 32'hF0);
      chk("out_3e", 32'(uout), 32'h3E);
      rd_reg(12'h004, r); chk("rd_out_3e", r, 32'h3E);
      rd_reg(12'h008, r); chk("rd_set_zero", r, 32'h0);

      // rising-edge interrupt timing on bit 0
      wr(12'h014, 32'h01);
      cycles(3);
      @(negedge clk); pin[0] = 1'b1;
      @(posedge clk); #1; chk("edge_n", 32'(irq), 32'h0);
      @(posedge clk); #1; chk("edge_n1", 32'(irq), 32'h0);
      @(posedge clk); #1; chk("edge_n2", 32'(irq), 32'h1);
      rd_reg(12'h020, r); chk("stat_01", r, 32'h01);
      wr(12'h020, 32'h01);
      chk("w1c_int", 32'(irq), 32'h0);

      // level-low on bit 3 re-sets after clear
      wr(12'h018, 32'h08);
      wr(12'h01C, 32'h08);
      wr(12'h014, 32'h08);
      cycles(3);
      wr(12'h020, 32'h08);
      rd_reg(12'h020, r); chk("lvl_reset", r & 32'h08, 32'h08);

      // edge event and W1C on the same edge: set wins
      wr(12'h018, 32'h00);
      wr(12'h01C, 32'h00);
      wr(12'h014, 32'h01);
      @(negedge clk); pin[0] = 1'b0;
      cycles(4);
      wr(12'h020, 32'hFF);
      @(negedge clk); pin[0] = 1'b1;
      @(posedge clk);
      wr(12'h020, 32'h01);
      rd_reg(12'h020, r); chk("set_wins", r & 32'h01, 32'h01);

      // error responses
      rd_reg(12'h024, r); chk("unmapped_rd", r, 32'h0);
      chk("unmapped_err_model", 32'(m_err(1'b0, 12'h024)), 32'h1);
      rd_reg(12'h010, r);
      wr(12'h010, 32'hA5);
      rd_reg(12'h010, r); chk("in_after_err", r, 32'(m_in()));

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         logic [AW-1:0] a;
         logic          w;
         if ($urandom_range(2) == 0) pin = W'($urandom);
         a = AW'($urandom_range(10) * 4);
         if ($urandom_range(7) == 0) a = AW'($urandom_range(4095));
         w = ($urandom_range(1) == 1);
         apb_acc(w, a, $urandom, r);
         chk_out();
      end

      // reset in the middle of a write with live state
      wr(12'h004, 32'hFF);
      wr(12'h018, 32'h01);
      wr(12'h01C, 32'h00);
      wr(12'h014, 32'h01);
      @(negedge clk); pin[0] = 1'b1;
      cycles(4);
      rd_reg(12'h020, r); chk("pre_rst_stat", r & 32'h01, 32'h01);
      @(negedge clk);
      apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = 12'h004; apb.PWDATA = 32'h55;
      @(negedge clk);
      apb.PENABLE = 1;
      #2 rst = 1'b1;
      #1;
      chk("async_out", 32'(uout), 32'h0);
      chk("async_dir", 32'(udir), 32'h0);
      chk("async_int", 32'(irq), 32'h0);
      chk("async_prdata", apb.PRDATA, 32'h0);
      chk("async_pslverr", 32'(apb.PSLVERR), 32'h0);
      chk("async_pready", 32'(apb.PREADY), 32'h1);
      @(posedge clk); #1;
      apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
      @(negedge clk); rst = 1'b0;
      cycles(5);
      chk("post_rst_out", 32'(uout), 32'h0);
      rd_reg(12'h004, r); chk("post_rst_rd_out", r, 32'h0);
      rd_reg(12'h020, r); chk("post_rst_stat", r, 32'h0);
      chk("post_rst_int", 32'(irq), 32'h0);
      rd_reg(12'h010, r); chk("post_rst_in", r & 32'h01, 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb_upio_gen.md
APB_UPIO_GEN -- requirements
Module: apb_upio_gen

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, sets the width of the APB address port.
REQ-002 Parameter UPIO_WIDTH, default 8, range 1..32, sets the number of user I/O channels.
REQ-003 Parameter SYNC_STAGES, default 2, range 2..4, sets the depth of the input synchronizer.
REQ-004 Port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port PADDR, input, APB_ADDR_WIDTH bits: APB address; bits [1:0] ignored.
REQ-007 Port PWDATA, input, 32 bits: APB write data.
REQ-008 Port PWRITE, input, 1 bit: APB write strobe.
REQ-009 Port PSEL, input, 1 bit: APB select.
REQ-010 Port PENABLE, input, 1 bit: APB enable.
REQ-011 Port PRDATA, output, 32 bits: APB read data.
REQ-012 Port PREADY, output, 1 bit: APB ready.
REQ-013 Port PSLVERR, output, 1 bit: APB error.
REQ-014 Port upio_in_i, input, UPIO_WIDTH bits: asynchronous pin inputs.
REQ-015 Port upio_out_o, output, UPIO_WIDTH bits: pin output values.
REQ-016 Port upio_dir_o, output, UPIO_WIDTH bits: pin direction, 1 = output.
REQ-017 Port int_o, output, 1 bit: level interrupt request.

Function
REQ-018 The register map SHALL be: 0x00 DIR RW; 0x04 OUT RW; 0x08 OUT_SET WO; 0x0C OUT_CLR WO; 0x10 IN RO; 0x14 INT_EN RW; 0x18 INT_TYPE RW (0 edge, 1 level); 0x1C INT_POL RW (0 rising/high, 1 falling/low); 0x20 INT_STATUS R/W1C.
REQ-019 PREADY SHALL be constant 1 (zero wait states); a write SHALL take effect at the clock edge where PSEL&PENABLE&PWRITE=1.
REQ-020 Reads SHALL return the register in bits [UPIO_WIDTH-1:0], zeros above; OUT_SET/OUT_CLR SHALL read 0.
REQ-021 A write SHALL use only PWDATA[UPIO_WIDTH-1:0].
REQ-022 PSLVERR SHALL be 1 during the access phase for an unmapped address or a write to IN; such an access SHALL change no state and SHALL read 0.
REQ-023 Writing OUT_SET SHALL perform OUT |= wdata; writing OUT_CLR SHALL perform OUT &= ~wdata.
REQ-024 upio_out_o SHALL equal OUT and upio_dir_o SHALL equal DIR, both driven directly from registers.
REQ-025 upio_in_i SHALL pass through a SYNC_STAGES-flop synchronizer; IN SHALL be the last stage.
REQ-026 A pin value stable before edge N SHALL be readable in IN after edge N+SYNC_STAGES-1.
REQ-027 The block SHALL keep a one-stage history register prev <= IN.
REQ-028 Per bit i, with INT_EN[i]=1, the event condition SHALL be:
  - edge, POL=0: IN&~prev
  - edge, POL=1: ~IN&prev
  - level, POL=0: IN
  - level, POL=1: ~IN
REQ-029 An event SHALL set INT_STATUS[i] at the edge after it is visible in IN (edge N+SYNC_STAGES for REQ-026 timing).
REQ-030 Bits with INT_EN[i]=0 SHALL never be set by events; their existing status SHALL be held.
REQ-031 A W1C write SHALL clear the addressed status bits.
REQ-032 If an event and a W1C hit the same bit in the same cycle, the set SHALL win.
REQ-033 In level mode, a bit cleared while the level persists SHALL re-set on the next edge.
REQ-034 int_o SHALL equal |(INT_STATUS & INT_EN), combinational from registers only.
REQ-035 Changing INT_TYPE/INT_POL SHALL NOT modify INT_STATUS; software clears stale bits.

Reset
REQ-036 While rst_i=1, all registers SHALL be 0 asynchronously: DIR, OUT, INT_EN, INT_TYPE, INT_POL, INT_STATUS, synchronizer stages and prev.
REQ-037 During reset, upio_out_o, upio_dir_o, int_o and PSLVERR SHALL be 0, PRDATA SHALL be 0 and PREADY SHALL be 1.
REQ-038 Reset asserted mid-transfer SHALL abort the write with no partial update.
REQ-039 After release, a pin already high with INT_EN=0 SHALL produce no status bit.

Verification
REQ-040 Write DIR=0xF0, OUT=0x0F, OUT_SET=0x30, OUT_CLR=0x01 -> upio_dir_o=0xF0, upio_out_o=0x3E, read OUT=0x3E.
REQ-041 INT_EN=0x01, rising edge: drive upio_in_i[0] 0->1 before edge N -> IN[0]=1 after N+1, INT_STATUS=0x01 and int_o=1 after N+2; W1C 0x01 -> int_o=0.
REQ-042 Level-low on bit 3 (TYPE=0x08, POL=0x08, EN=0x08), pin held 0, W1C 0x08 -> status reads 0x08 again on the next read.
REQ-043 A rising edge on bit 0 coinciding with a W1C of bit 0 -> INT_STATUS[0]=1 afterwards.
REQ-044 Read 0x24, write 0x10 -> PSLVERR=1, PRDATA=0, IN unchanged.
REQ-045 Assert rst_i mid-operation with OUT=0xFF, INT_STATUS=0x01 -> all outputs 0 immediately, without waiting for a clock edge.
